// File: rtl/tile_sched_pkg.sv
// Shared types, route encodings and geometry helpers for the tile dispatch scheduler.
package tile_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    STREAM   = 3'd2,
    WAIT_DEC = 3'd3,
    DISPATCH = 3'd4,
    DRAIN    = 3'd5
  } state_e;

  localparam logic ROUTE_CNN  = 1'b1;
  localparam logic ROUTE_LITE = 1'b0;

  function automatic int unsigned calcNumTiles(input int unsigned imgW, input int unsigned imgH,
                                               input int unsigned tileW, input int unsigned tileH);
    return (imgW / tileW) * (imgH / tileH);
  endfunction

  function automatic int unsigned calcIdxW(input int unsigned numTiles);
    return (numTiles > 1) ? $clog2(numTiles) : 1;
  endfunction

endpackage

// File: rtl/tile_dispatch_scheduler_engine_slot.sv
// One engine's job slot: single-job busy flag plus a saturating per-frame dispatch counter.
module engine_slot
  import tile_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iClr,
  input  logic             iStart,
  input  logic             iDone,
  output logic             oBusy,
  output logic [CNT_W-1:0] oCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Start wins over Done so a job launched in the completion cycle stays tracked.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oBusy  <= 1'b0;
      oCount <= '0;
    end else begin
      if (iStart) begin
        oBusy <= 1'b1;
      end else if (iDone) begin
        oBusy <= 1'b0;
      end
      if (iClr) begin
        oCount <= '0;
      end else if (iStart && (oCount != CNT_MAX)) begin
        oCount <= oCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tile_dispatch_scheduler.sv
// Frame sequencer: requests each tile, waits for a routing decision, dispatches to the
// CNN or lite engine and signals frame completion once both engines are idle.
module tile_dispatch_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 32,
  parameter int unsigned IMG_HEIGHT  = 16,
  parameter int unsigned TILE_WIDTH  = 16,
  parameter int unsigned TILE_HEIGHT = 16,
  parameter int unsigned DEC_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned NUM_TILES  = calcNumTiles(IMG_WIDTH, IMG_HEIGHT, TILE_WIDTH, TILE_HEIGHT),
  localparam int unsigned IDX_W      = calcIdxW(NUM_TILES)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  output logic             oBusy,
  output logic             oFrameDone,
  output logic             oTileReq,
  output logic [IDX_W-1:0] oTileIdx,
  input  logic             iTileDone,
  input  logic             iDecisionValid,
  input  logic             iRouteToCnn,
  output logic             oCnnStart,
  input  logic             iCnnReady,
  input  logic             iCnnDone,
  output logic             oLiteStart,
  input  logic             iLiteReady,
  input  logic             iLiteDone,
  output logic [CNT_W-1:0] oCnnCount,
  output logic [CNT_W-1:0] oLiteCount,
  output logic             oTimeoutErr
);

  localparam int unsigned TO_W = (DEC_TIMEOUT > 1) ? $clog2(DEC_TIMEOUT) : 1;

  state_e          state;
  logic            decValid;
  logic            decRoute;
  logic [TO_W-1:0] decTimer;
  logic            cnnBusy;
  logic            liteBusy;
  logic            cnnDoneQ;
  logic            liteDoneQ;
  logic            frameClr;
  logic            targetFree;

  // Completions are only meaningful while a frame is running.
  assign cnnDoneQ  = iCnnDone  && (state != IDLE);
  assign liteDoneQ = iLiteDone && (state != IDLE);
  assign frameClr  = (state == IDLE) && iStart;

  // A completing job frees its engine in the same cycle.
  assign targetFree = (decRoute == ROUTE_CNN) ? (iCnnReady  && (!cnnBusy  || cnnDoneQ))
                                              : (iLiteReady && (!liteBusy || liteDoneQ));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      oBusy       <= 1'b0;
      oFrameDone  <= 1'b0;
      oTileReq    <= 1'b0;
      oTileIdx    <= '0;
      oCnnStart   <= 1'b0;
      oLiteStart  <= 1'b0;
      oTimeoutErr <= 1'b0;
      decValid    <= 1'b0;
      decRoute    <= ROUTE_LITE;
      decTimer    <= '0;
    end else begin
      oFrameDone <= 1'b0;
      oTileReq   <= 1'b0;
      oCnnStart  <= 1'b0;
      oLiteStart <= 1'b0;

      // First decision per tile wins; later ones are dropped until dispatch clears the latch.
      if (((state == STREAM) || (state == WAIT_DEC)) && iDecisionValid && !decValid) begin
        decValid <= 1'b1;
        decRoute <= iRouteToCnn;
      end

      case (state)
        IDLE: begin
          if (iStart) begin
            state       <= REQ;
            oBusy       <= 1'b1;
            oTileReq    <= 1'b1;
            oTileIdx    <= '0;
            oTimeoutErr <= 1'b0;
          end
        end
        REQ: state <= STREAM;
        STREAM: begin
          if (iTileDone) begin
            decTimer <= '0;
            state    <= decValid ? DISPATCH : WAIT_DEC;
          end
        end
        WAIT_DEC: begin
          if (decValid || iDecisionValid) begin
            state <= DISPATCH;
          end else if (decTimer == TO_W'(DEC_TIMEOUT - 1)) begin
            decValid    <= 1'b1;
            decRoute    <= ROUTE_CNN;
            oTimeoutErr <= 1'b1;
            state       <= DISPATCH;
          end else begin
            decTimer <= decTimer + TO_W'(1);
          end
        end
        DISPATCH: begin
          if (targetFree) begin
            decValid <= 1'b0;
            if (decRoute == ROUTE_CNN) begin
              oCnnStart <= 1'b1;
            end else begin
              oLiteStart <= 1'b1;
            end
            if (oTileIdx == IDX_W'(NUM_TILES - 1)) begin
              state <= DRAIN;
            end else begin
              oTileIdx <= oTileIdx + IDX_W'(1);
              oTileReq <= 1'b1;
              state    <= REQ;
            end
          end
        end
        DRAIN: begin
          // A start pulse still in flight has not reached its busy flag yet.
          if (!cnnBusy && !liteBusy && !oCnnStart && !oLiteStart) begin
            oFrameDone <= 1'b1;
            oBusy      <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  engine_slot #(.CNT_W(CNT_W)) uCnnSlot (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClr   (frameClr),
    .iStart (oCnnStart),
    .iDone  (cnnDoneQ),
    .oBusy  (cnnBusy),
    .oCount (oCnnCount)
  );

  engine_slot #(.CNT_W(CNT_W)) uLiteSlot (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClr   (frameClr),
    .iStart (oLiteStart),
    .iDone  (liteDoneQ),
    .oBusy  (liteBusy),
    .oCount (oLiteCount)
  );

endmodule
